// File: rtl/sensor_frame_capture.sv
// Collects four id-tagged sensor readings and publishes them atomically as one frame.
// Optional macro SENSOR_AVG_EN: publish a rounded running average instead of raw readings.
`timescale 1ns/1ps
module sensor_frame_capture #(
    parameter int TIMEOUT = 1000,
    parameter int TIMER_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_id,
    input  logic [7:0] in_data,
    output logic [7:0] sensor1,
    output logic [7:0] sensor2,
    output logic [7:0] sensor3,
    output logic [7:0] sensor4,
    output logic       frame_valid,
    output logic       timeout_err,
    output logic [7:0] frame_count
);
    typedef enum logic [1:0] {IDLE, COLLECT, PUBLISH} state_t;

    state_t               state, state_nxt;
    logic [3:0]           mask, mask_nxt, mask_hit;
    logic [TIMER_W-1:0]   timer, timer_nxt;
    logic [3:0][7:0]      shadow;
    logic [3:0][7:0]      pub, pub_val;
    logic                 shadow_we, pub_en, to_err;

    assign mask_hit = mask | (4'b0001 << in_id);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            mask  <= '0;
            timer <= '0;
        end else begin
            state <= state_nxt;
            mask  <= mask_nxt;
            timer <= timer_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mask_nxt  = mask;
        timer_nxt = timer;
        shadow_we = 1'b0;
        pub_en    = 1'b0;
        to_err    = 1'b0;
        in_ready  = !rst && (state != PUBLISH);
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    shadow_we = 1'b1;
                    mask_nxt  = 4'b0001 << in_id;
                    timer_nxt = '0;
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                // completion takes priority over a coincident timeout
                if (in_valid && in_ready && mask_hit == 4'hF) begin
                    shadow_we = 1'b1;
                    mask_nxt  = mask_hit;
                    timer_nxt = '0;
                    state_nxt = PUBLISH;
                end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
                    to_err    = 1'b1;
                    mask_nxt  = '0;
                    timer_nxt = '0;
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer + 1'b1;
                    if (in_valid && in_ready) begin
                        shadow_we = 1'b1;
                        mask_nxt  = mask_hit;
                    end
                end
            end
            PUBLISH: begin
                pub_en    = 1'b1;
                mask_nxt  = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            shadow <= '0;
        else if (shadow_we) shadow[in_id] <= in_data;
    end

`ifdef SENSOR_AVG_EN
    logic first_frame;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         first_frame <= 1'b1;
        else if (pub_en) first_frame <= 1'b0;
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign pub_val[g] = first_frame ? shadow[g]
                          : 8'((9'(pub[g]) + 9'(shadow[g]) + 9'd1) >> 1);
    end
`else
    assign pub_val = shadow;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pub         <= '0;
            frame_valid <= 1'b0;
            timeout_err <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_valid <= pub_en;
            timeout_err <= to_err;
            if (pub_en) begin
                pub         <= pub_val;
                frame_count <= frame_count + 8'd1;
            end
        end
    end

    assign sensor1 = pub[0];
    assign sensor2 = pub[1];
    assign sensor3 = pub[2];
    assign sensor4 = pub[3];
endmodule

// File: tb/tb_sensor_frame_capture.sv
// Directed bench for sensor_frame_capture with a short timeout.
`timescale 1ns/1ps
module tb_sensor_frame_capture;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_id;
    logic [7:0] in_data;
    logic [7:0] sensor1, sensor2, sensor3, sensor4;
    logic       frame_valid, timeout_err;
    logic [7:0] frame_count;

    int total = 0;
    int bad   = 0;
    logic [7:0] es [4];

    sensor_frame_capture #(.TIMEOUT(8), .TIMER_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_id(in_id), .in_data(in_data),
        .sensor1(sensor1), .sensor2(sensor2), .sensor3(sensor3), .sensor4(sensor4),
        .frame_valid(frame_valid), .timeout_err(timeout_err), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [1:0] id, input logic [7:0] d);
        in_valid = 1'b1;
        in_id    = id;
        in_data  = d;
        step();
    endtask

    function automatic logic [7:0] expect_val(input logic [7:0] prev, input logic [7:0] nw,
                                              input bit first);
`ifdef SENSOR_AVG_EN
        logic [8:0] s;
        s = {1'b0, prev} + {1'b0, nw} + 9'd1;
        return first ? nw : s[8:1];
`else
        return nw;
`endif
    endfunction

    task automatic pub_expect(input logic [7:0] a, b, c, d, input bit first);
        es[0] = expect_val(es[0], a, first);
        es[1] = expect_val(es[1], b, first);
        es[2] = expect_val(es[2], c, first);
        es[3] = expect_val(es[3], d, first);
    endtask

    task automatic chk_sensors(input string tag);
        chk({tag, "_s1"}, {8'h0, sensor1}, {8'h0, es[0]});
        chk({tag, "_s2"}, {8'h0, sensor2}, {8'h0, es[1]});
        chk({tag, "_s3"}, {8'h0, sensor3}, {8'h0, es[2]});
        chk({tag, "_s4"}, {8'h0, sensor4}, {8'h0, es[3]});
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_id = 2'd0; in_data = 8'h0;
        es[0] = 8'h0; es[1] = 8'h0; es[2] = 8'h0; es[3] = 8'h0;
        #3;
        chk_sensors("rst");
        chk("rst_fv", 16'(frame_valid), 16'd0);
        chk("rst_te", 16'(timeout_err), 16'd0);
        chk("rst_fc", 16'(frame_count), 16'd0);
        chk("rst_rdy", 16'(in_ready), 16'd0);
        step();
        rst = 1'b0;
        #1;
        chk("idle_rdy", 16'(in_ready), 16'd1);

        // basic frame
        xfer(2'd0, 8'h10); xfer(2'd1, 8'h20); xfer(2'd2, 8'h30); xfer(2'd3, 8'h40);
        in_valid = 1'b0;
        chk("f1_pub_rdy", 16'(in_ready), 16'd0);
        chk("f1_pub_fv", 16'(frame_valid), 16'd0);
        step();
        pub_expect(8'h10, 8'h20, 8'h30, 8'h40, 1'b1);
        chk("f1_fv", 16'(frame_valid), 16'd1);
        chk_sensors("f1");
        chk("f1_fc", 16'(frame_count), 16'd1);
        chk("f1_rdy", 16'(in_ready), 16'd1);
        step();
        chk("f1_fv_end", 16'(frame_valid), 16'd0);

        // duplicate id: newest wins
        xfer(2'd2, 8'h05); xfer(2'd2, 8'h55); xfer(2'd0, 8'h01); xfer(2'd1, 8'h02);
        chk("dup_nofv", 16'(frame_valid), 16'd0);
        xfer(2'd3, 8'h03);
        in_valid = 1'b0;
        step();
        pub_expect(8'h01, 8'h02, 8'h55, 8'h03, 1'b0);
        chk("dup_fv", 16'(frame_valid), 16'd1);
        chk("dup_te", 16'(timeout_err), 16'd0);
        chk_sensors("dup");
        chk("dup_fc", 16'(frame_count), 16'd2);
        step();
        chk("dup_fv_end", 16'(frame_valid), 16'd0);

        // timeout after two readings
        xfer(2'd0, 8'hEE); xfer(2'd1, 8'hEF);
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("to_early", 16'(timeout_err), 16'd0);
        end
        step();
        chk("to_te", 16'(timeout_err), 16'd1);
        chk("to_fv", 16'(frame_valid), 16'd0);
        chk_sensors("to");
        chk("to_fc", 16'(frame_count), 16'd2);
        step();
        chk("to_te_end", 16'(timeout_err), 16'd0);
        xfer(2'd3, 8'hA3); xfer(2'd1, 8'hA1); xfer(2'd0, 8'hA0); xfer(2'd2, 8'hA2);
        in_valid = 1'b0;
        step();
        pub_expect(8'hA0, 8'hA1, 8'hA2, 8'hA3, 1'b0);
        chk("after_to_fv", 16'(frame_valid), 16'd1);
        chk_sensors("after_to");
        chk("after_to_fc", 16'(frame_count), 16'd3);
        step();

        // completing transfer on the timeout edge
        xfer(2'd0, 8'hC0); xfer(2'd1, 8'hC1); xfer(2'd2, 8'hC2);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        xfer(2'd3, 8'hC3);
        in_valid = 1'b0;
        chk("edge_te", 16'(timeout_err), 16'd0);
        chk("edge_rdy", 16'(in_ready), 16'd0);
        step();
        pub_expect(8'hC0, 8'hC1, 8'hC2, 8'hC3, 1'b0);
        chk("edge_fv", 16'(frame_valid), 16'd1);
        chk("edge_te2", 16'(timeout_err), 16'd0);
        chk_sensors("edge");
        chk("edge_fc", 16'(frame_count), 16'd4);
        step();

        // reset mid-frame
        xfer(2'd0, 8'h11); xfer(2'd1, 8'h22); xfer(2'd2, 8'h33);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        es[0] = 8'h0; es[1] = 8'h0; es[2] = 8'h0; es[3] = 8'h0;
        chk_sensors("mid_rst");
        chk("mid_rst_fc", 16'(frame_count), 16'd0);
        chk("mid_rst_rdy", 16'(in_ready), 16'd0);
        step();
        rst = 1'b0;
        #1;
        xfer(2'd0, 8'h40); xfer(2'd1, 8'h40); xfer(2'd2, 8'h40); xfer(2'd3, 8'h40);
        in_valid = 1'b0;
        step();
        pub_expect(8'h40, 8'h40, 8'h40, 8'h40, 1'b1);
        chk("post_rst_fv", 16'(frame_valid), 16'd1);
        chk_sensors("post_rst");
        chk("post_rst_fc", 16'(frame_count), 16'd1);
        step();

        // second frame: averaged when the feature is built in
        xfer(2'd0, 8'h81); xfer(2'd1, 8'h81); xfer(2'd2, 8'h81); xfer(2'd3, 8'h81);
        in_valid = 1'b0;
        step();
`ifdef SENSOR_AVG_EN
        es[0] = 8'h61; es[1] = 8'h61; es[2] = 8'h61; es[3] = 8'h61;
`else
        es[0] = 8'h81; es[1] = 8'h81; es[2] = 8'h81; es[3] = 8'h81;
`endif
        chk("f81_fv", 16'(frame_valid), 16'd1);
        chk_sensors("f81");
        chk("f81_fc", 16'(frame_count), 16'd2);
        step();
        chk("f81_fv_end", 16'(frame_valid), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sensor_frame_capture.md
Name: sensor_frame_capture

Overview:
- Upstream acquisition stage for the baggage drop datapath.
- Accepts individual sensor readings over a valid/ready byte interface, each tagged with a sensor id.
- Assembles a complete frame of four readings and publishes them atomically on registered outputs sensor1..sensor4. These outputs feed the sensor inputs of baggage_drop directly.
- Incomplete frames that stall longer than a timeout are discarded and flagged.

Parameters:
- TIMEOUT, 1000, max cycles allowed in COLLECT before a partial frame is abandoned (>= 2).
- TIMER_W, 16, width of the timeout counter; must satisfy 2^TIMER_W > TIMEOUT.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  reading present on in_id/in_data.
- in_ready  output  1  block can accept a reading this cycle.
- in_id  input  2  sensor index: 0..3 maps to sensor1..sensor4.
- in_data  input  8  reading value.
- sensor1  output  8  published reading, sensor 0.
- sensor2  output  8  published reading, sensor 1.
- sensor3  output  8  published reading, sensor 2.
- sensor4  output  8  published reading, sensor 3.
- frame_valid  output  1  one-cycle pulse: sensor1..4 updated this cycle.
- timeout_err  output  1  one-cycle pulse: partial frame discarded.
- frame_count  output  8  number of published frames, wraps 255->0.

Behaviour:
- Reset (async, immediate):
  - sensor1..4 = 0, frame_valid = 0, timeout_err = 0, frame_count = 0.
  - Internal: state = IDLE, mask = 0, timer = 0, shadow registers = 0.
  - in_ready = 0 while rst is high.
- Transfer rule:
  - A reading is accepted at a rising edge when in_valid && in_ready.
  - in_ready is combinational: 1 in IDLE and COLLECT, 0 in PUBLISH.
  - Transmitter must hold in_id/in_data stable while in_valid && !in_ready.
- State IDLE:
  - On transfer: shadow[in_id] <= in_data, mask <= bit in_id, timer <= 0, go to COLLECT.
  - Otherwise hold.
- State COLLECT:
  - On transfer: shadow[in_id] <= in_data, mask |= bit in_id.
  - A duplicate id overwrites the earlier value (newest wins) and raises no error.
  - If mask including this transfer == 4'b1111: go to PUBLISH, timer <= 0.
  - Otherwise timer increments every cycle spent in COLLECT.
  - If timer == TIMEOUT-1 with no frame-completing transfer at that edge:
    - timeout_err = 1 for the next cycle, mask <= 0, timer <= 0, go to IDLE.
    - shadow contents are discarded; sensor outputs are unchanged.
    - A non-completing transfer at that same edge is also discarded.
  - Simultaneous completing transfer and timeout: completion wins, no timeout_err.
- State PUBLISH (exactly one cycle):
  - At the exiting edge: sensorN <= shadow[N-1], frame_valid = 1 for one cycle, frame_count += 1, mask <= 0, go to IDLE.
  - Latency: outputs change 2 edges after the frame-completing transfer edge.
  - Earliest next accepted reading is at the edge following publication.
- Outputs:
  - sensor1..4 are stable between frame_valid pulses, so downstream combinational logic sees a coherent frame.
  - frame_valid and timeout_err are never high in the same cycle.
- Reset mid-operation: the partial frame is lost and outputs return to 0 immediately.

Optional Feature:
- Macro: SENSOR_AVG_EN.
- Defined:
  - Each published value = (previous published value + new shadow value + 1) >> 1, computed at 9 bits and truncated to 8 bits.
  - The first frame after reset publishes raw values, tracked by a first-frame flag that is cleared on the first publication.
  - Timing is unchanged.
- Undefined: raw shadow values are published directly.

Test Plan:
- Reset, then ids 0,1,2,3 with data 0x10,0x20,0x30,0x40 on consecutive cycles -> 2 edges after the 4th transfer: sensor1..4 = 0x10/0x20/0x30/0x40, frame_valid pulses once, frame_count = 1, in_ready low for one cycle.
- Ids 2,2,0,1,3 with data 0x05,0x55,0x01,0x02,0x03 -> sensor3 = 0x55, no error, exactly one frame_valid.
- TIMEOUT=8: ids 0,1 then idle -> timeout_err pulses 1 cycle after the 8th COLLECT cycle, outputs keep their previous values, next 4-id frame publishes correctly.
- Completing transfer lands exactly on the timeout edge -> frame published, timeout_err stays 0.
- Assert rst after 3 readings -> all outputs 0 immediately; after release, a fresh 4-id frame publishes with frame_count = 1.
- With SENSOR_AVG_EN: frame 1 all 0x40, frame 2 all 0x81 -> frame 2 publishes 0x61 on every sensor; without the macro it publishes 0x81.
